// File: rtl/dmem_responder.sv
// Doubleword data-memory responder: one outstanding ld/sd request, fixed access
// latency, valid/ready response channel with an error flag for bad addresses.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [63:0]   mem [DEPTH];
    logic [28:0]   index;
    logic          acc_err;
    logic          mem_we;

    assign index   = addr_q[31:3];
    assign acc_err = (addr_q[2:0] != 3'b000) || ({3'b000, index} >= 32'(DEPTH));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    // The access happens on the edge that leaves WAIT, so the write
                    // commits only if reset has not aborted the request by then.
                    state_d = S_RESP;
                    err_d   = acc_err;
                    if (acc_err) begin
                        rdata_d = '0;
                    end else if (we_q) begin
                        mem_we  = 1'b1;
                        rdata_d = '0;
                    end else begin
                        rdata_d = mem[index[AW-1:0]];
                    end
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // The array has no reset; contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[index[AW-1:0]] <= wdata_q;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed literal checks, a LATENCY=1 back-to-back run,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_dmem_responder;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_ready = 1'b0;
    logic        req_ready, resp_valid, resp_err;
    logic [63:0] resp_rdata;

    logic        l1_req_valid = 1'b0;
    logic        l1_req_we = 1'b0;
    logic [31:0] l1_req_addr = '0;
    logic [63:0] l1_req_wdata = '0;
    logic        l1_resp_ready = 1'b0;
    logic        l1_req_ready, l1_resp_valid, l1_resp_err;
    logic [63:0] l1_resp_rdata;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    always #5 clock = ~clock;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH(16), .LATENCY(1)) dut_l1 (
        .clock(clock), .reset(reset),
        .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_we(l1_req_we),
        .req_addr(l1_req_addr), .req_wdata(l1_req_wdata),
        .resp_valid(l1_resp_valid), .resp_ready(l1_resp_ready),
        .resp_rdata(l1_resp_rdata), .resp_err(l1_resp_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: got timeout, want handshake", name);
    endtask

    // Transaction-level reference: one pending request that resolves LATENCY edges
    // after acceptance, then a response that lives until the requester takes it.
    logic [63:0] model_mem [0:DEPTH-1];
    bit          m_busy = 1'b0;
    bit          m_valid = 1'b0;
    bit          m_err = 1'b0;
    logic [63:0] m_rdata = '0;
    longint      cyc = 0;
    longint      m_due = 0;
    bit          m_we = 1'b0;
    logic [31:0] m_addr = '0;
    logic [63:0] m_wdata = '0;
    logic [31:0] m_idx;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_rdata = '0;
        end else begin
            cyc++;
            if (m_valid) begin
                if (resp_ready) begin
                    m_valid = 1'b0;
                    m_rdata = '0;
                    m_err   = 1'b0;
                end
            end else if (m_busy) begin
                if (cyc == m_due) begin
                    m_idx = m_addr >> 3;
                    m_err = (m_addr[2:0] != 3'd0) || (m_idx >= 32'(DEPTH));
                    if (m_err) begin
                        m_rdata = '0;
                    end else if (m_we) begin
                        model_mem[m_idx] = m_wdata;
                        m_rdata = '0;
                    end else begin
                        m_rdata = model_mem[m_idx];
                    end
                    m_busy  = 1'b0;
                    m_valid = 1'b1;
                end
            end else if (req_valid) begin
                m_busy  = 1'b1;
                m_due   = cyc + LATENCY;
                m_we    = req_we;
                m_addr  = req_addr;
                m_wdata = req_wdata;
            end
        end
    end

    always @(negedge clock) begin
        if (check_en) begin
            check("model_req_ready", 64'(req_ready), 64'(!(m_busy || m_valid)));
            check("model_resp_valid", 64'(resp_valid), 64'(m_valid));
            check("model_resp_rdata", resp_rdata, m_rdata);
            check("model_resp_err", 64'(resp_err), 64'(m_err));
        end
    end

    // Runs one request to completion; entered and left just after a rising edge.
    task automatic do_txn(input bit we, input logic [31:0] addr, input logic [63:0] wdata,
                          input int stall, input bit bogus, input logic [63:0] hold_rdata,
                          output logic [63:0] rdata, output logic err, output int lat);
        int n;
        rdata = '0;
        err   = 1'b0;
        lat   = -1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        while (n < 50) begin
            @(negedge clock);
            if (req_ready) break;
            n++;
        end
        if (n == 50) begin
            timeout_fail("accept_timeout");
            req_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = $urandom;
        req_wdata = {$urandom, $urandom};
        n = 0;
        while (n < 50) begin
            @(negedge clock);
            if (resp_valid) break;
            n++;
        end
        if (n == 50) begin
            timeout_fail("resp_timeout");
            return;
        end
        lat   = n;
        rdata = resp_rdata;
        err   = resp_err;
        for (int i = 0; i < stall; i++) begin
            @(posedge clock);
            #1;
            if (bogus) begin
                req_valid = 1'b1;
                req_we    = 1'b1;
                req_addr  = 32'h10;
                req_wdata = 64'hBAD0_BAD0_BAD0_BAD0;
            end
            @(negedge clock);
            check("stall_resp_valid", 64'(resp_valid), 64'd1);
            check("stall_resp_rdata", resp_rdata, hold_rdata);
            check("stall_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        @(negedge clock);
        check("post_hs_req_ready", 64'(req_ready), 64'd1);
        check("post_hs_resp_valid", 64'(resp_valid), 64'd0);
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned k;
        k = $urandom_range(0, 9);
        if (k <= 5) return 32'($urandom_range(0, DEPTH - 1)) << 3;
        if (k == 6) return (32'($urandom_range(0, DEPTH - 1)) << 3) | 32'($urandom_range(1, 7));
        if (k == 7) return 32'(DEPTH + $urandom_range(0, 15)) << 3;
        if (k == 8) return 32'h7F8;
        return $urandom;
    endfunction

    localparam logic [63:0] L1_W = 64'h0123_4567_89AB_CDEF;
    bit          l1_exp_ready [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bit          l1_exp_valid [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [63:0] l1_exp_rdata [6] = '{64'd0, 64'd0, 64'd0, 64'd0, L1_W, 64'd0};

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat;

        @(negedge clock);
        check_en = 1'b1;
        check("reset_req_ready", 64'(req_ready), 64'd1);
        check("reset_resp_valid", 64'(resp_valid), 64'd0);
        check("reset_resp_rdata", resp_rdata, 64'd0);
        check("reset_resp_err", 64'(resp_err), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // LATENCY=1 instance: write then an immediately held read of the same word.
        l1_resp_ready = 1'b1;
        l1_req_valid  = 1'b1;
        l1_req_we     = 1'b1;
        l1_req_addr   = 32'h8;
        l1_req_wdata  = L1_W;
        @(negedge clock);
        check("l1_accept_ready", 64'(l1_req_ready), 64'd1);
        @(posedge clock);
        #1;
        l1_req_we    = 1'b0;
        l1_req_wdata = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("l1_req_ready", 64'(l1_req_ready), 64'(l1_exp_ready[i]));
            check("l1_resp_valid", 64'(l1_resp_valid), 64'(l1_exp_valid[i]));
            check("l1_resp_rdata", l1_resp_rdata, l1_exp_rdata[i]);
            check("l1_resp_err", 64'(l1_resp_err), 64'd0);
            if (i == 2) begin
                @(posedge clock);
                #1;
                l1_req_valid = 1'b0;
            end
        end
        @(posedge clock);
        #1;

        do_txn(1'b1, 32'h10, 64'hDEADBEEF_CAFEF00D, 0, 1'b0, '0, rd, er, lat);
        check("wr10_latency", 64'(lat), 64'd2);
        check("wr10_err", 64'(er), 64'd0);
        check("wr10_rdata", rd, 64'd0);
        do_txn(1'b0, 32'h10, '0, 0, 1'b0, '0, rd, er, lat);
        check("rd10_rdata", rd, 64'hDEADBEEF_CAFEF00D);
        check("rd10_err", 64'(er), 64'd0);
        do_txn(1'b0, 32'h13, '0, 0, 1'b0, '0, rd, er, lat);
        check("rd13_err", 64'(er), 64'd1);
        check("rd13_rdata", rd, 64'd0);
        do_txn(1'b0, 32'h10, '0, 0, 1'b0, '0, rd, er, lat);
        check("rd10_after_misalign", rd, 64'hDEADBEEF_CAFEF00D);
        do_txn(1'b1, 32'h0, 64'hA5A5_0000_0000_5A5A, 0, 1'b0, '0, rd, er, lat);
        do_txn(1'b1, 32'h20, 64'h2222_0000_0000_2222, 0, 1'b0, '0, rd, er, lat);
        do_txn(1'b1, 32'h800, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, '0, rd, er, lat);
        check("wr800_err", 64'(er), 64'd1);
        check("wr800_rdata", rd, 64'd0);
        do_txn(1'b0, 32'h0, '0, 0, 1'b0, '0, rd, er, lat);
        check("rd0_after_oob", rd, 64'hA5A5_0000_0000_5A5A);
        do_txn(1'b1, 32'h7F8, 64'h0000_07F8_07F8_0000, 0, 1'b0, '0, rd, er, lat);
        check("wr7f8_err", 64'(er), 64'd0);
        do_txn(1'b0, 32'h7F8, '0, 0, 1'b0, '0, rd, er, lat);
        check("rd7f8_rdata", rd, 64'h0000_07F8_07F8_0000);
        do_txn(1'b0, 32'h10, '0, 5, 1'b1, 64'hDEADBEEF_CAFEF00D, rd, er, lat);
        check("stall_rd10", rd, 64'hDEADBEEF_CAFEF00D);
        do_txn(1'b0, 32'h10, '0, 0, 1'b0, '0, rd, er, lat);
        check("rd10_after_ignored_req", rd, 64'hDEADBEEF_CAFEF00D);

        // Reset lands in WAIT before the commit edge; the write must vanish.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 64'h1111;
        @(negedge clock);
        check("abort_accept_ready", 64'(req_ready), 64'd1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        reset     = 1'b0;
        @(negedge clock);
        check("abort_req_ready", 64'(req_ready), 64'd1);
        check("abort_resp_valid", 64'(resp_valid), 64'd0);
        check("abort_resp_rdata", resp_rdata, 64'd0);
        check("abort_resp_err", 64'(resp_err), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        do_txn(1'b0, 32'h20, '0, 0, 1'b0, '0, rd, er, lat);
        check("rd20_after_abort", rd, 64'h2222_0000_0000_2222);

        for (int i = 0; i < DEPTH; i++) begin
            do_txn(1'b1, 32'(i) << 3, {32'hC0DE_0000 + 32'(i), 32'(i) ^ 32'h5A5A_5A5A},
                   0, 1'b0, '0, rd, er, lat);
        end

        for (int c = 0; c < 2500; c++) begin
            @(posedge clock);
            #1;
            reset      = ($urandom_range(0, 199) != 0);
            req_valid  = ($urandom_range(0, 2) != 0);
            req_we     = 1'($urandom_range(0, 1));
            req_addr   = rand_addr();
            req_wdata  = {$urandom, $urandom};
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clock);
        #1;
        reset     = 1'b1;
        req_valid = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder sitting on the memory side of the multicycle core's load/store path. It accepts one doubleword read (ld) or write (sd) request at a time from the control unit/datapath over a valid/ready handshake, models a fixed access latency, and returns read data or a write acknowledge over a valid/ready response channel. Misaligned or out-of-range accesses complete with an error flag and no side effect.

Parameters:
DEPTH, 256, number of 64-bit words in the array (power of two not required, >=1)
LATENCY, 2, cycles from request acceptance to resp_valid (>=1)

Ports:
clock  input  1  single clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
req_we  input  1  1 = write (sd), 0 = read (ld)
req_addr  input  32  byte address
req_wdata  input  64  write data
resp_valid  output  1  response present
resp_ready  input  1  requester takes response this cycle
resp_rdata  output  64  read data (0 for writes and errors)
resp_err  output  1  1 = misaligned or out-of-range access

Behaviour:
- Reset (reset=0, async): state IDLE, counter 0, req_ready=1 once state is IDLE, resp_valid=0, resp_rdata=0, resp_err=0. Memory array is NOT cleared.
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1, resp_valid=0. On edge with req_valid=1: latch we/addr/wdata, load counter with LATENCY-1, go WAIT.
- WAIT: req_ready=0. If counter!=0: decrement. If counter==0: perform access on that edge, go RESP.
- Access: index = addr[31:3]. err = (addr[2:0]!=0) or (index>=DEPTH). Read, no err: resp_rdata <= mem[index]. Write, no err: mem[index] <= wdata, resp_rdata <= 0. err: no write, resp_rdata <= 0, resp_err <= 1.
- Latency: request accepted at edge t -> resp_valid=1 in the cycle after edge t+LATENCY.
- RESP: resp_valid=1, req_ready=0; resp_rdata/resp_err held stable while resp_ready=0 (unbounded stall). Edge with resp_ready=1: go IDLE, resp_valid=0, resp_rdata/resp_err cleared to 0.
- No same-cycle turnaround: after response handshake, req_ready is 1 in the following cycle (IDLE); minimum 2 cycles between accepted requests beyond LATENCY.
- req_valid while req_ready=0 is ignored (not queued); requester must hold it.
- Only latched request fields are used after acceptance; changes on req_* during WAIT/RESP have no effect.
- Write commits only at the WAIT->RESP edge; reset asserted before that edge aborts the request with no memory change. Reset during RESP drops the response.
- Read-after-write to the same word returns the newly written value.

Test Plan:
- Reset then write addr=0x10, wdata=0xDEADBEEF_CAFEF00D, LATENCY=2 -> resp_valid 2 cycles after acceptance, resp_err=0, resp_rdata=0; subsequent read addr=0x10 -> resp_rdata=0xDEADBEEF_CAFEF00D.
- Read addr=0x13 (misaligned) -> resp_err=1, resp_rdata=0; read addr=0x10 afterwards still returns prior data (no corruption).
- Write addr=DEPTH*8 (=0x800 for DEPTH=256) -> resp_err=1, no array word changed; addr=0x7F8 -> resp_err=0.
- Read with resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable for all 5; req_ready=0 throughout; new req_valid ignored until IDLE.
- Write addr=0x20 wdata=0x1111, reset pulsed low in WAIT before commit edge -> after reset, read 0x20 returns pre-write value; outputs at reset values during reset.
- LATENCY=1 back-to-back: write 0x8 then read 0x8 with resp_ready=1 -> each response 1 cycle after acceptance, read returns written data, req_ready high the cycle after each response handshake.
